// File: rtl/psg_bank_ctrl_if.sv
// -----------------------------------------------------------------------------
// psg_bank_ctrl_if
// Bundles the sound-CPU write bus, the per-chip PSG handshake/data lines and
// the mixer/status outputs of psg_bank_ctrl.
//   cpu_a/cpu_wr/cpu_do : sound CPU A[14:12], level write strobe, data
//   psg_rdy/psg_aout    : per-chip ready and 8-bit analogue-out codes
//   prom_din            : sample PROM data
//   psg_we_n/psg_d      : per-chip active-low write strobe and data
//   psgvol/sout         : PROM volume latch and mixed PCM output
//   busy/ovf/to_err     : activity and sticky per-chip error flags
// slave modport is the controller side, master is the CPU/board side.
// -----------------------------------------------------------------------------
interface psg_bank_ctrl_if #(
  parameter int NUM_PSG = 3,
  parameter int OUT_W   = 16
);
  logic [2:0]           cpu_a;
  logic                 cpu_wr;
  logic [7:0]           cpu_do;
  logic [NUM_PSG-1:0]   psg_rdy;
  logic [NUM_PSG*8-1:0] psg_aout;
  logic [7:0]           prom_din;
  logic [NUM_PSG-1:0]   psg_we_n;
  logic [NUM_PSG*8-1:0] psg_d;
  logic [3:0]           psgvol;
  logic [OUT_W-1:0]     sout;
  logic                 busy;
  logic [NUM_PSG-1:0]   ovf;
  logic [NUM_PSG-1:0]   to_err;

  modport master (
    output cpu_a, cpu_wr, cpu_do, psg_rdy, psg_aout, prom_din,
    input  psg_we_n, psg_d, psgvol, sout, busy, ovf, to_err
  );

  modport slave (
    input  cpu_a, cpu_wr, cpu_do, psg_rdy, psg_aout, prom_din,
    output psg_we_n, psg_d, psgvol, sout, busy, ovf, to_err
  );
endinterface

// File: rtl/psg_bank_ctrl.sv
// -----------------------------------------------------------------------------
// psg_bank_ctrl
// Write sequencer and mixer for NUM_PSG SN76489-class sound chips.
// Sound-CPU writes (rising edge of the cpu_wr level, seen on sndclk-enabled
// cycles) are decoded by A[14:12]: codes below NUM_PSG queue a byte into that
// chip's FIFO, VOL_SEL loads the 4-bit PROM volume latch, others are ignored.
// Each chip has its own FIFO and IDLE/STROBE/RELEASE handshake FSM with a
// ready timeout. Chip outputs and the scaled PROM sample are summed and
// saturated into sout.
// Ports:
//   clk12m : system clock, all flops on its rising edge
//   reset  : asynchronous active-high reset
//   sndclk : clock enable, all state advances only when high
//   bus    : psg_bank_ctrl_if slave modport (CPU bus, chip handshake, mix out)
// -----------------------------------------------------------------------------
module psg_bank_ctrl #(
  parameter int NUM_PSG = 3,
  parameter int VOL_SEL = 5,
  parameter int QDEPTH  = 4,
  parameter int GAIN    = 170,
  parameter int OUT_W   = 16,
  parameter int RDY_TO  = 255
) (
  input  logic           clk12m,
  input  logic           reset,
  input  logic           sndclk,
  psg_bank_ctrl_if.slave bus
);

  localparam int PW    = $clog2(QDEPTH);
  localparam int CW    = PW + 1;
  localparam int TW    = $clog2(RDY_TO + 1);
  localparam int SUM_W = 17 + $clog2(NUM_PSG + 1);
  // One spare bit so the saturation limit is always representable.
  localparam int CMP_W = ((OUT_W > SUM_W) ? OUT_W : SUM_W) + 1;
  localparam logic [CMP_W-1:0] SAT_MAX = {{(CMP_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_STROBE  = 2'd1,
    S_RELEASE = 2'd2
  } state_e;

  logic               wr_q;
  logic               accept_s;
  logic [3:0]         psgvol_q, psgvol_d;
  logic [OUT_W-1:0]   sout_q, sout_d;
  logic               busy_q, busy_d;
  logic [NUM_PSG-1:0] chip_busy_s;
  logic [CMP_W-1:0]   sum_s;

  // A held strobe is only accepted on its first enabled cycle.
  assign accept_s = sndclk & bus.cpu_wr & ~wr_q;

  // Volume latch next-state.
  always_comb begin
    psgvol_d = psgvol_q;
    if (accept_s && (bus.cpu_a == 3'(VOL_SEL))) begin
      psgvol_d = bus.cpu_do[3:0];
    end else begin
      psgvol_d = psgvol_q;
    end
  end

  // Mixer sum at full width, then saturate to the output range.
  always_comb begin
    sum_s = CMP_W'(bus.prom_din) * CMP_W'(psgvol_q) * CMP_W'(2);
    for (int i = 0; i < NUM_PSG; i++) begin
      sum_s = sum_s + CMP_W'(bus.psg_aout[8*i +: 8]) * CMP_W'(GAIN);
    end
    if (sum_s > SAT_MAX) begin
      sout_d = SAT_MAX[OUT_W-1:0];
    end else begin
      sout_d = sum_s[OUT_W-1:0];
    end
  end

  assign busy_d = |chip_busy_s;

  // Shared registers: strobe history, volume, mixer output, busy.
  always_ff @(posedge clk12m or posedge reset) begin
    if (reset) begin
      wr_q     <= 1'b0;
      psgvol_q <= 4'h0;
      sout_q   <= {OUT_W{1'b0}};
      busy_q   <= 1'b0;
    end else if (sndclk) begin
      wr_q     <= bus.cpu_wr;
      psgvol_q <= psgvol_d;
      sout_q   <= sout_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.psgvol = psgvol_q;
  assign bus.sout   = sout_q;
  assign bus.busy   = busy_q;

  for (genvar gi = 0; gi < NUM_PSG; gi++) begin : g_chip
    logic [7:0]    mem_q [QDEPTH];
    logic [PW-1:0] wp_q, rp_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q;
    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d, tinc_s;
    logic          we_n_q, we_n_d;
    logic          to_err_q, to_err_d;
    logic [7:0]    d_q, d_d;
    logic          push_s, pop_s, push_ok_s, full_s, empty_s, rdy_s, timeout_s;

    assign rdy_s     = bus.psg_rdy[gi];
    assign push_s    = accept_s && (bus.cpu_a == 3'(gi));
    assign empty_s   = (cnt_q == CW'(0));
    assign full_s    = (cnt_q == CW'(QDEPTH));
    assign pop_s     = sndclk && (state_q == S_IDLE) && !empty_s;
    // A full FIFO still takes the push when the same cycle pops an entry.
    assign push_ok_s = push_s && (!full_s || pop_s);
    assign tinc_s    = timer_q + TW'(1);
    assign timeout_s = (tinc_s == TW'(RDY_TO));

    // FIFO occupancy next-state.
    always_comb begin
      case ({push_ok_s, pop_s})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end

    // FIFO storage, pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk12m or posedge reset) begin
      if (reset) begin
        for (int k = 0; k < QDEPTH; k++) begin
          mem_q[k] <= 8'h00;
        end
        wp_q  <= {PW{1'b0}};
        rp_q  <= {PW{1'b0}};
        cnt_q <= {CW{1'b0}};
        ovf_q <= 1'b0;
      end else begin
        if (push_ok_s) begin
          mem_q[wp_q] <= bus.cpu_do;
          wp_q        <= wp_q + PW'(1);
        end
        if (push_s && !push_ok_s) begin
          ovf_q <= 1'b1;
        end
        if (pop_s) begin
          rp_q <= rp_q + PW'(1);
        end
        cnt_q <= cnt_d;
      end
    end

    // Handshake FSM state register plus its registered outputs.
    always_ff @(posedge clk12m or posedge reset) begin
      if (reset) begin
        state_q  <= S_IDLE;
        timer_q  <= {TW{1'b0}};
        we_n_q   <= 1'b1;
        d_q      <= 8'h00;
        to_err_q <= 1'b0;
      end else if (sndclk) begin
        state_q  <= state_d;
        timer_q  <= timer_d;
        we_n_q   <= we_n_d;
        d_q      <= d_d;
        to_err_q <= to_err_d;
      end
    end

    // Handshake FSM next-state; the timer restarts for each ready phase.
    always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      case (state_q)
        S_IDLE: begin
          if (!empty_s) begin
            state_d = S_STROBE;
            timer_d = {TW{1'b0}};
          end else begin
            state_d = S_IDLE;
          end
        end
        S_STROBE: begin
          if (!rdy_s) begin
            state_d = S_RELEASE;
            timer_d = {TW{1'b0}};
          end else if (timeout_s) begin
            state_d = S_IDLE;
            timer_d = {TW{1'b0}};
          end else begin
            timer_d = tinc_s;
          end
        end
        S_RELEASE: begin
          if (rdy_s) begin
            state_d = S_IDLE;
            timer_d = {TW{1'b0}};
          end else if (timeout_s) begin
            state_d = S_IDLE;
            timer_d = {TW{1'b0}};
          end else begin
            timer_d = tinc_s;
          end
        end
        default: begin
          state_d = S_IDLE;
          timer_d = {TW{1'b0}};
        end
      endcase
    end

    // Handshake FSM outputs: strobe, data pop, timeout flag.
    always_comb begin
      we_n_d   = we_n_q;
      d_d      = d_q;
      to_err_d = to_err_q;
      case (state_q)
        S_IDLE: begin
          if (!empty_s) begin
            we_n_d = 1'b0;
            d_d    = mem_q[rp_q];
          end else begin
            we_n_d = 1'b1;
          end
        end
        S_STROBE: begin
          if (!rdy_s) begin
            we_n_d = 1'b1;
          end else if (timeout_s) begin
            we_n_d   = 1'b1;
            to_err_d = 1'b1;
          end else begin
            we_n_d = 1'b0;
          end
        end
        S_RELEASE: begin
          we_n_d = 1'b1;
          if (!rdy_s && timeout_s) begin
            to_err_d = 1'b1;
          end else begin
            to_err_d = to_err_q;
          end
        end
        default: begin
          we_n_d = 1'b1;
        end
      endcase
    end

    assign chip_busy_s[gi]     = (state_d != S_IDLE) || (cnt_d != CW'(0));
    assign bus.psg_we_n[gi]    = we_n_q;
    assign bus.psg_d[8*gi +: 8] = d_q;
    assign bus.ovf[gi]         = ovf_q;
    assign bus.to_err[gi]      = to_err_q;
  end

endmodule

// File: doc/psg_bank_ctrl.md
Name: psg_bank_ctrl

Overview:
- Parametrised successor to the sound-board PSG write logic: write sequencing plus mixing for NUM_PSG SN76489-class chips.
- Sound-CPU memory writes with A15=1 are decoded by A[14:12] into either a per-chip queued write or the PROM-sample volume latch.
- Each chip gets its own FIFO and ready handshake, so back-to-back writes are never lost.
- Chip outputs and the PROM sample are mixed into one saturated signed-free (unsigned) PCM word `sout` for the audio path.

Parameters:
- NUM_PSG, 3, number of PSG chips (1..6); sel codes 0..NUM_PSG-1 address them.
- VOL_SEL, 5, A[14:12] code that writes the 4-bit PROM volume latch.
- QDEPTH, 4, per-chip write FIFO depth (power of 2, >=2).
- GAIN, 170, per-PSG mix multiplier (8-bit).
- OUT_W, 16, output width.
- RDY_TO, 255, sndclk-enabled cycles to wait for each ready phase before abort.

Ports:
- clk12m  in  1  system clock; all flops on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- sndclk  in  1  clock enable; all state advances only when high.
- cpu_a  in  3  sound CPU A[14:12].
- cpu_wr  in  1  level write strobe (~WR & ~MREQ & A15).
- cpu_do  in  8  sound CPU data out.
- psg_rdy  in  NUM_PSG  ready_o of each chip.
- psg_aout  in  NUM_PSG*8  chip analogue-out codes, chip i at [8i+7:8i].
- prom_din  in  8  sample PROM data.
- psg_we_n  out  NUM_PSG  active-low write/chip-enable to each chip.
- psg_d  out  NUM_PSG*8  data to each chip.
- psgvol  out  4  volume latch.
- sout  out  OUT_W  mixed audio.
- busy  out  1  OR of all per-chip non-IDLE or FIFO non-empty.
- ovf  out  NUM_PSG  sticky FIFO-overflow flag per chip.
- to_err  out  NUM_PSG  sticky ready-timeout flag per chip.

Behaviour:
- Reset values: psg_we_n all 1, psg_d 0, psgvol 0, sout 0, busy 0, ovf 0, to_err 0, FIFOs empty, FSMs IDLE, timers 0, wr_d 0.
- Write capture:
  - wr_d registers cpu_wr on enabled cycles; an accept occurs when cpu_wr=1 and wr_d=0.
  - A strobe held over several enabled cycles counts once.
  - On accept with cpu_a<NUM_PSG: push cpu_do into FIFO[cpu_a].
  - On accept with cpu_a==VOL_SEL: psgvol<=cpu_do[3:0], effective the next cycle.
  - Any other code is ignored.
- Overflow: a push to a full FIFO is dropped, ovf[i]<=1, contents unchanged.
- Per-chip FSM, evaluated on enabled cycles:
  - IDLE: if the FIFO is non-empty, pop into psg_d[i], set we_n[i]=0, clear the timer, go STROBE. Pop latency is 1 enabled cycle from push.
  - STROBE: we_n=0. If psg_rdy[i]=0 (chip accepted), set we_n=1 and go RELEASE. Else increment the timer; on reaching RDY_TO set we_n=1, to_err[i]<=1, go IDLE.
  - RELEASE: we_n=1. If psg_rdy[i]=1, go IDLE. A new pop can occur on the following enabled cycle, giving a minimum 3 enabled cycles per write. Else increment the timer; at RDY_TO set to_err and go IDLE.
  - psg_d[i] is held stable from pop until the next pop.
- Simultaneous push and pop on the same FIFO in the same cycle is legal. Count is unchanged, and a full FIFO is not flagged as overflow when a pop occurs that same cycle.
- Mixer, registered on enabled cycles with 1 enabled-cycle latency:
  - sum = Σ psg_aout[i]*GAIN + prom_din*psgvol*2, computed at full width (≥ 8+8+clog2(NUM_PSG)+1 bits).
  - sout = sum saturated to 2^OUT_W−1; there is no wrap-around.
- Reset mid-operation: all FSMs return to IDLE immediately (async), we_n released, and queued writes are discarded.
- Disabled cycles (sndclk=0): all registers hold, and a strobe edge spanning only disabled cycles is not seen until the next enabled cycle.

Test Plan:
- Single write: cpu_a=1, cpu_do=0x9F, one-cycle strobe; chip 1 models rdy low 2 cycles after we_n falls → psg_d[15:8]=0x9F, we_n[1] low until rdy=0, chip 1 sees exactly one write, busy returns to 0.
- Burst + overflow (QDEPTH=4): 6 strobes to chip 0 with rdy held low → 1 in STROBE/RELEASE + 4 queued, 6th sets ovf[0]=1. Release rdy → 5 writes delivered in order.
- Held strobe: cpu_wr high for 10 enabled cycles to cpu_a=2 → exactly one push.
- Volume latch: cpu_a=5, data 0xAB → psgvol=0xB. With prom_din=0x80 and all aout 0 → sout=0x80*11*2=2816 one cycle later.
- Saturation: all aout=0xFF, prom_din=0xFF, psgvol=0xF → sout=0xFFFF. With all aout=0x10, prom 0, NUM_PSG=3 → sout=48*170=8160.
- Timeout and reset: rdy stuck at 1 for RDY_TO cycles → to_err set, FSM IDLE. Assert reset while STROBE → we_n=1 immediately, FIFOs empty, flags cleared.
